// File: rtl/axi_slave_pkg.sv
// Shared types and constants for the AXI-to-SRAM slave wrapper.
// AXI field widths live here so that the wrapper and its users agree on them.
package axi_slave_pkg;

    localparam int AXI_IDS_BITS   = 8;
    localparam int AXI_ADDR_BITS  = 32;
    localparam int AXI_DATA_BITS  = 32;
    localparam int AXI_STRB_BITS  = 4;
    localparam int AXI_LEN_BITS   = 4;
    localparam int AXI_SIZE_BITS  = 3;
    localparam int AXI_BURST_BITS = 2;

    localparam int MEM_AW_DEFAULT = 14;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WRESP,
        ST_RD_REQ,
        ST_RD_DATA
    } state_e;

    // Byte strobes to the SRAM's active-low per-bit write mask.
    function automatic logic [AXI_DATA_BITS-1:0] strb_to_bweb(input logic [AXI_STRB_BITS-1:0] strb);
        logic [AXI_DATA_BITS-1:0] bweb;
        bweb = '1;
        for (int i = 0; i < AXI_STRB_BITS; i++) begin
            bweb[8*i +: 8] = {8{~strb[i]}};
        end
        return bweb;
    endfunction

endpackage

// File: rtl/sram_slave_wrapper.sv
// AXI slave endpoint: serves one INCR burst at a time against a single-port
// synchronous SRAM (active-low CEB/WEB/BWEB, word addressed).
module sram_slave_wrapper
    import axi_slave_pkg::*;
#(
    parameter int ADDR_LSB = 2,
    parameter int MEM_AW   = MEM_AW_DEFAULT
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,

    input  logic [AXI_IDS_BITS-1:0]   S_AWID,
    input  logic [AXI_ADDR_BITS-1:0]  S_AWAddr,
    input  logic [AXI_LEN_BITS-1:0]   S_AWLen,
    input  logic [AXI_SIZE_BITS-1:0]  S_AWSize,
    input  logic [AXI_BURST_BITS-1:0] S_AWBurst,
    input  logic                      S_AWValid,
    output logic                      S_AWReady,

    input  logic [AXI_DATA_BITS-1:0]  S_WData,
    input  logic [AXI_STRB_BITS-1:0]  S_WStrb,
    input  logic                      S_WLast,
    input  logic                      S_WValid,
    output logic                      S_WReady,

    output logic [AXI_IDS_BITS-1:0]   S_BID,
    output logic [1:0]                S_BResp,
    output logic                      S_BValid,
    input  logic                      S_BReady,

    input  logic [AXI_IDS_BITS-1:0]   S_ARID,
    input  logic [AXI_ADDR_BITS-1:0]  S_ARAddr,
    input  logic [AXI_LEN_BITS-1:0]   S_ARLen,
    input  logic [AXI_SIZE_BITS-1:0]  S_ARSize,
    input  logic [AXI_BURST_BITS-1:0] S_ARBurst,
    input  logic                      S_ARValid,
    output logic                      S_ARReady,

    output logic [AXI_IDS_BITS-1:0]   S_RID,
    output logic [AXI_DATA_BITS-1:0]  S_RData,
    output logic [1:0]                S_RResp,
    output logic                      S_RLast,
    output logic                      S_RValid,
    input  logic                      S_RReady,

    output logic                      mem_CEB,
    output logic                      mem_WEB,
    output logic [AXI_DATA_BITS-1:0]  mem_BWEB,
    output logic [MEM_AW-1:0]         mem_A,
    output logic [AXI_DATA_BITS-1:0]  mem_DI,
    input  logic [AXI_DATA_BITS-1:0]  mem_DO
);

    state_e                    state_q, state_d;
    logic [AXI_IDS_BITS-1:0]   id_q,    id_d;
    logic [MEM_AW-1:0]         addr_q,  addr_d;
    logic [AXI_LEN_BITS-1:0]   len_q,   len_d;
    logic [AXI_LEN_BITS-1:0]   cnt_q,   cnt_d;

    logic                      rd_last;

    // Size/burst are ignored (always INCR, 4-byte beats); upper address bits alias.
    logic unused_ok;
    assign unused_ok = ^{S_AWSize, S_AWBurst, S_ARSize, S_ARBurst, S_AWAddr, S_ARAddr};

    assign rd_last = (cnt_q == len_q);

    // NOTE: every signal written below gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;

        S_AWReady = 1'b0;
        S_ARReady = 1'b0;
        S_WReady  = 1'b0;
        mem_CEB   = 1'b1;
        mem_WEB   = 1'b1;
        mem_BWEB  = '1;
        mem_A     = '0;
        mem_DI    = '0;

        unique case (state_q)
            ST_IDLE: begin
                S_AWReady = 1'b1;
                S_ARReady = ~S_AWValid;
                if (S_AWValid) begin
                    id_d    = S_AWID;
                    addr_d  = S_AWAddr[ADDR_LSB +: MEM_AW];
                    len_d   = S_AWLen;
                    cnt_d   = '0;
                    state_d = ST_WR;
                end else if (S_ARValid) begin
                    id_d    = S_ARID;
                    addr_d  = S_ARAddr[ADDR_LSB +: MEM_AW];
                    len_d   = S_ARLen;
                    cnt_d   = '0;
                    state_d = ST_RD_REQ;
                end
            end
            ST_WR: begin
                S_WReady = 1'b1;
                if (S_WValid) begin
                    mem_CEB  = 1'b0;
                    mem_WEB  = 1'b0;
                    mem_A    = addr_q;
                    mem_DI   = S_WData;
                    mem_BWEB = strb_to_bweb(S_WStrb);
                    addr_d   = addr_q + MEM_AW'(1);
                    cnt_d    = cnt_q + AXI_LEN_BITS'(1);
                    // WLast alone closes the burst, whatever the beat count says.
                    if (S_WLast) state_d = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (S_BReady) state_d = ST_IDLE;
            end
            ST_RD_REQ: begin
                mem_CEB = 1'b0;
                mem_A   = addr_q;
                state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                // SRAM holds mem_DO while CEB stays high, so RData is stable here.
                if (S_RReady) begin
                    if (rd_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        addr_d  = addr_q + MEM_AW'(1);
                        cnt_d   = cnt_q + AXI_LEN_BITS'(1);
                        state_d = ST_RD_REQ;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Readies must read 0 while reset is held, even though IDLE advertises them.
        if (!ARESETn) begin
            S_AWReady = 1'b0;
            S_ARReady = 1'b0;
            S_WReady  = 1'b0;
        end
    end

    assign S_BValid = (state_q == ST_WRESP);
    assign S_BID    = id_q;
    assign S_BResp  = RESP_OKAY;

    assign S_RValid = (state_q == ST_RD_DATA);
    assign S_RID    = id_q;
    assign S_RData  = S_RValid ? mem_DO : '0;
    assign S_RResp  = RESP_OKAY;
    assign S_RLast  = S_RValid & rd_last;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sram_slave_wrapper.sv
// Directed bench for sram_slave_wrapper with a behavioural single-port SRAM.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_sram_slave_wrapper;

    logic        clk;
    logic        rst_n;

    logic [7:0]  aw_id;
    logic [31:0] aw_addr;
    logic [3:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic        aw_valid;
    logic        aw_ready;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_last;
    logic        w_valid;
    logic        w_ready;
    logic [7:0]  b_id;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        b_ready;
    logic [7:0]  ar_id;
    logic [31:0] ar_addr;
    logic [3:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        ar_valid;
    logic        ar_ready;
    logic [7:0]  r_id;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic        r_valid;
    logic        r_ready;

    logic        mem_ceb;
    logic        mem_web;
    logic [31:0] mem_bweb;
    logic [13:0] mem_a;
    logic [31:0] mem_di;
    logic [31:0] mem_do;

    logic [31:0] mem [0:16383];
    int          n_reads;
    logic        bd_en;
    logic [13:0] bd_addr;
    logic [31:0] bd_data;

    int          n_checks;
    int          n_fail;
    int          reads_before;

    sram_slave_wrapper dut (
        .ACLK      (clk),
        .ARESETn   (rst_n),
        .S_AWID    (aw_id),
        .S_AWAddr  (aw_addr),
        .S_AWLen   (aw_len),
        .S_AWSize  (aw_size),
        .S_AWBurst (aw_burst),
        .S_AWValid (aw_valid),
        .S_AWReady (aw_ready),
        .S_WData   (w_data),
        .S_WStrb   (w_strb),
        .S_WLast   (w_last),
        .S_WValid  (w_valid),
        .S_WReady  (w_ready),
        .S_BID     (b_id),
        .S_BResp   (b_resp),
        .S_BValid  (b_valid),
        .S_BReady  (b_ready),
        .S_ARID    (ar_id),
        .S_ARAddr  (ar_addr),
        .S_ARLen   (ar_len),
        .S_ARSize  (ar_size),
        .S_ARBurst (ar_burst),
        .S_ARValid (ar_valid),
        .S_ARReady (ar_ready),
        .S_RID     (r_id),
        .S_RData   (r_data),
        .S_RResp   (r_resp),
        .S_RLast   (r_last),
        .S_RValid  (r_valid),
        .S_RReady  (r_ready),
        .mem_CEB   (mem_ceb),
        .mem_WEB   (mem_web),
        .mem_BWEB  (mem_bweb),
        .mem_A     (mem_a),
        .mem_DI    (mem_di),
        .mem_DO    (mem_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port SRAM: masked write, or read with data out the next cycle and held.
    always @(posedge clk) begin
        if (bd_en) begin
            mem[bd_addr] <= bd_data;
        end else if (!mem_ceb) begin
            if (!mem_web) begin
                mem[mem_a] <= (mem[mem_a] & mem_bweb) | (mem_di & ~mem_bweb);
            end else begin
                mem_do  <= mem[mem_a];
                n_reads <= n_reads + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [13:0] addr, input logic [31:0] data);
        bd_en   = 1'b1;
        bd_addr = addr;
        bd_data = data;
        step();
        bd_en   = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_reads  = 0;
        rst_n    = 1'b0;
        bd_en    = 1'b0;
        bd_addr  = '0;
        bd_data  = '0;
        aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = 3'd2; aw_burst = 2'b01; aw_valid = 1'b0;
        w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0;
        b_ready = 1'b0;
        ar_id = '0; ar_addr = '0; ar_len = '0; ar_size = 3'd2; ar_burst = 2'b01; ar_valid = 1'b0;
        r_ready = 1'b0;

        preload(14'd4, 32'hDEAD_BEEF);
        for (int i = 8; i < 12; i++) preload(14'(i), 32'hAAAA_AAAA);
        preload(14'd16, 32'h1111_1111);
        preload(14'd17, 32'h2222_2222);
        preload(14'd18, 32'h3333_3333);
        preload(14'd0, 32'h0);
        preload(14'h3FFF, 32'h0);

        // Reset values while ARESETn is held low.
        @(negedge clk);
        check("rst_awready", aw_ready, 0);
        check("rst_arready", ar_ready, 0);
        check("rst_wready", w_ready, 0);
        check("rst_bvalid", b_valid, 0);
        check("rst_rvalid", r_valid, 0);
        check("rst_ceb_web", {mem_ceb, mem_web}, 2'b11);
        check("rst_bweb", mem_bweb, 32'hFFFF_FFFF);
        check("rst_rdata_rid", {r_data, r_id}, 40'h0);
        step();
        rst_n = 1'b1;
        step();

        // Single read: word 4, ID 0x12.
        ar_valid = 1'b1; ar_addr = 32'h10; ar_len = 4'd0; ar_id = 8'h12;
        @(negedge clk);
        check("rd1_arready", ar_ready, 1);
        step();
        ar_valid = 1'b0;
        @(negedge clk);
        check("rd1_req_ceb_web", {mem_ceb, mem_web}, 2'b01);
        check("rd1_req_addr", mem_a, 14'd4);
        check("rd1_req_rvalid", r_valid, 0);
        step();
        r_ready = 1'b1;
        @(negedge clk);
        check("rd1_rvalid", r_valid, 1);
        check("rd1_rdata", r_data, 32'hDEAD_BEEF);
        check("rd1_rlast", r_last, 1);
        check("rd1_rid", r_id, 8'h12);
        check("rd1_rresp", r_resp, 2'b00);
        step();
        r_ready = 1'b0;
        @(negedge clk);
        check("rd1_done", r_valid, 0);

        // 4-beat write at word 8 with a partial strobe on beat 2.
        step();
        aw_valid = 1'b1; aw_addr = 32'h20; aw_len = 4'd3; aw_id = 8'h34;
        @(negedge clk);
        check("wr4_awready", aw_ready, 1);
        step();
        aw_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_valid = 1'b1;
            w_data  = 32'(i + 1);
            w_strb  = (i == 1) ? 4'b0011 : 4'b1111;
            w_last  = (i == 3);
            @(negedge clk);
            check("wr4_wready", w_ready, 1);
            check("wr4_ceb_web", {mem_ceb, mem_web}, 2'b00);
            check("wr4_addr", mem_a, 14'(8 + i));
            check("wr4_di", mem_di, 32'(i + 1));
            check("wr4_bweb", mem_bweb, (i == 1) ? 32'hFFFF_0000 : 32'h0000_0000);
            step();
        end
        w_valid = 1'b0; w_last = 1'b0;
        @(negedge clk);
        check("wr4_bvalid", b_valid, 1);
        check("wr4_bid", b_id, 8'h34);
        check("wr4_bresp", b_resp, 2'b00);
        check("wr4_wready_off", w_ready, 0);
        step();
        @(negedge clk);
        check("wr4_bvalid_hold", b_valid, 1);
        step();
        b_ready = 1'b1;
        step();
        b_ready = 1'b0;
        @(negedge clk);
        check("wr4_bvalid_drop", b_valid, 0);
        check("wr4_mem8", mem[8], 32'h0000_0001);
        check("wr4_mem9", mem[9], 32'hAAAA_0002);
        check("wr4_mem10", mem[10], 32'h0000_0003);
        check("wr4_mem11", mem[11], 32'h0000_0004);

        // Read backpressure: 3 beats from word 16, beat 1 held for 3 cycles.
        step();
        reads_before = n_reads;
        ar_valid = 1'b1; ar_addr = 32'h40; ar_len = 4'd2; ar_id = 8'h56;
        step();
        ar_valid = 1'b0;
        step();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_rvalid", r_valid, 1);
            check("bp_rdata0", r_data, 32'h1111_1111);
            check("bp_rlast0", r_last, 0);
            check("bp_ceb_idle", mem_ceb, 1);
            step();
        end
        r_ready = 1'b1;
        step();
        @(negedge clk);
        check("bp_req_gap", r_valid, 0);
        step();
        @(negedge clk);
        check("bp_rdata1", r_data, 32'h2222_2222);
        check("bp_rlast1", r_last, 0);
        step();
        step();
        @(negedge clk);
        check("bp_rdata2", r_data, 32'h3333_3333);
        check("bp_rlast2", r_last, 1);
        check("bp_rid", r_id, 8'h56);
        step();
        r_ready = 1'b0;
        @(negedge clk);
        check("bp_done", r_valid, 0);
        check("bp_read_count", n_reads - reads_before, 3);

        // Same-cycle AW and AR: write wins, read follows after BReady.
        step();
        aw_valid = 1'b1; aw_addr = 32'h80; aw_len = 4'd0; aw_id = 8'h01;
        ar_valid = 1'b1; ar_addr = 32'h80; ar_len = 4'd0; ar_id = 8'h02;
        @(negedge clk);
        check("tie_awready", aw_ready, 1);
        check("tie_arready", ar_ready, 0);
        step();
        aw_valid = 1'b0;
        w_valid = 1'b1; w_data = 32'h55; w_strb = 4'hF; w_last = 1'b1;
        @(negedge clk);
        check("tie_wr_arready", ar_ready, 0);
        step();
        w_valid = 1'b0; w_last = 1'b0;
        @(negedge clk);
        check("tie_bvalid", b_valid, 1);
        check("tie_bid", b_id, 8'h01);
        b_ready = 1'b1;
        step();
        b_ready = 1'b0;
        @(negedge clk);
        check("tie_arready_idle", ar_ready, 1);
        step();
        ar_valid = 1'b0;
        step();
        r_ready = 1'b1;
        @(negedge clk);
        check("tie_rdata", r_data, 32'h55);
        check("tie_rid", r_id, 8'h02);
        step();
        r_ready = 1'b0;

        // Address wrap: word 0x3FFF then word 0.
        aw_valid = 1'b1; aw_addr = 32'hFFFC; aw_len = 4'd1; aw_id = 8'h07;
        step();
        aw_valid = 1'b0;
        w_valid = 1'b1; w_data = 32'hA1; w_strb = 4'hF; w_last = 1'b0;
        @(negedge clk);
        check("wrap_addr0", mem_a, 14'h3FFF);
        step();
        w_data = 32'hA2; w_last = 1'b1;
        @(negedge clk);
        check("wrap_addr1", mem_a, 14'h0000);
        step();
        w_valid = 1'b0; w_last = 1'b0;
        b_ready = 1'b1;
        step();
        b_ready = 1'b0;
        @(negedge clk);
        check("wrap_mem_top", mem[16383], 32'hA1);
        check("wrap_mem_zero", mem[0], 32'hA2);

        // Early WLast on beat 1 of a Len=3 burst.
        step();
        aw_valid = 1'b1; aw_addr = 32'h100; aw_len = 4'd3; aw_id = 8'h09;
        step();
        aw_valid = 1'b0;
        w_valid = 1'b1; w_data = 32'hBEEF; w_strb = 4'hF; w_last = 1'b1;
        step();
        w_valid = 1'b0; w_last = 1'b0;
        @(negedge clk);
        check("early_bvalid", b_valid, 1);
        check("early_wready", w_ready, 0);
        check("early_bid", b_id, 8'h09);
        b_ready = 1'b1;
        step();
        b_ready = 1'b0;

        // Reset pulsed in the middle of a read burst.
        ar_valid = 1'b1; ar_addr = 32'h40; ar_len = 4'd3; ar_id = 8'h55;
        step();
        ar_valid = 1'b0;
        step();
        @(negedge clk);
        check("mid_rvalid_pre", r_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rvalid_rst", r_valid, 0);
        check("mid_rlast_rst", r_last, 0);
        check("mid_rdata_rid_rst", {r_data, r_id}, 40'h0);
        check("mid_readies_rst", {aw_ready, ar_ready, w_ready}, 3'b000);
        check("mid_ceb_rst", mem_ceb, 1);
        step();
        rst_n = 1'b1;
        ar_valid = 1'b1; ar_addr = 32'h10; ar_len = 4'd0; ar_id = 8'h21;
        @(negedge clk);
        check("post_arready", ar_ready, 1);
        step();
        ar_valid = 1'b0;
        step();
        r_ready = 1'b1;
        @(negedge clk);
        check("post_rdata", r_data, 32'hDEAD_BEEF);
        check("post_rid", r_id, 8'h21);
        check("post_rlast", r_last, 1);
        step();
        r_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
